mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports cpu_addr (in 8), cpu_wdata (in 8) and cpu_we (in 1): the CPU memory request, carrying abus, dbus and storeMem.
REQ-004 SHALL have port cpu_rdata, out 8: equal to ram_rdata in every state (the CPU mbus).
REQ-005 SHALL have port cpu_stall, out 1: the CPU shall hold all its registers while this is high.
REQ-006 SHALL have ports ldr_req (in 1), ldr_addr (in 8), ldr_wdata (in 8) and ldr_we (in 1): the loader/debug request.
REQ-007 SHALL have port ldr_gnt, out 1: the loader owns the RAM port.
REQ-008 SHALL have ports ldr_rdata (out 8) and ldr_valid (out 1): the registered loader read return.
REQ-009 SHALL have ports ram_addr (out 8), ram_wdata (out 8) and ram_we (out 1): to the 256x8 RAM.
REQ-010 SHALL have port ram_rdata, in 8: combinational RAM read data for ram_addr.

Function
REQ-011 SHALL implement a 4-state FSM: CPU_OWN, DRAIN, LDR_OWN, HANDBACK.
REQ-012 In CPU_OWN: ram_addr/ram_wdata/ram_we = cpu_addr/cpu_wdata/cpu_we; cpu_stall=0; ldr_gnt=0.
REQ-013 CPU_OWN -> DRAIN on a clk edge with ldr_req=1; otherwise stay in CPU_OWN.
REQ-014 CPU_OWN SHALL last at least one full cycle, so the CPU always gets at least one unstalled cycle between loader tenures.
REQ-015 DRAIN: cpu_stall=1, ldr_gnt=0, ram_we=0; go to LDR_OWN unconditionally next edge.
REQ-016 LDR_OWN: cpu_stall=1, ldr_gnt=1; ram_addr=ldr_addr, ram_wdata=ldr_wdata, ram_we=ldr_we&ldr_req.
REQ-017 A loader access is any edge in LDR_OWN with ldr_req=1; one access per cycle, no wait states.
REQ-018 LDR_OWN -> HANDBACK on an edge with ldr_req=0; that cycle performs no access.
REQ-019 HANDBACK: cpu_stall=1, ldr_gnt=0, ram_we=0; go to CPU_OWN unconditionally next edge.
REQ-020 cpu_stall, ldr_gnt and ram_we-suppression SHALL be Moore outputs decoded from state only (ram_we additionally gated by the requester's we).
REQ-021 Loader read: on an access edge with ldr_we=0, ldr_rdata<=ram_rdata and ldr_valid<=1; on every other edge ldr_valid<=0 and ldr_rdata holds.
REQ-022 Loader write: ram_we=1 during the access cycle; the RAM captures on that edge; ldr_valid stays 0.
REQ-023 ldr_req dropping in CPU_OWN after an edge has not yet sampled it SHALL cause no transition.
REQ-024 cpu_we asserted while cpu_stall=1 SHALL never reach ram_we.
REQ-025 The 8-bit address SHALL be passed through unchanged; no address wrap or check beyond 8 bits.

Reset
REQ-026 reset_n=0 SHALL immediately force state=CPU_OWN, cpu_stall=0, ldr_gnt=0, ldr_valid=0, ldr_rdata=8'h00 and burst count=0, asynchronously.
REQ-027 Reset asserted mid-tenure (DRAIN/LDR_OWN/HANDBACK) SHALL abort the tenure with no further RAM write; the first edge after release evaluates REQ-013.

Configuration
REQ-028 Macro ARB_STARVE_GUARD_EN: defined -> 4-bit burst counter, cleared on entering LDR_OWN and incremented per access; the 8th access edge moves to HANDBACK even with ldr_req=1.
REQ-029 ARB_STARVE_GUARD_EN undefined -> no counter; LDR_OWN is held for as long as ldr_req=1.

Verification
REQ-030 Reset, ldr_req=0 for 10 cycles, cpu_we=1, cpu_addr=8'h40, cpu_wdata=8'h5A -> ram[8'h40]=8'h5A; cpu_stall and ldr_gnt stay 0.
REQ-031 ldr_req=1 at edge N -> cpu_stall=1 after edge N; ldr_gnt=1 after edge N+1; write 8'hC3 to 8'h10 at edge N+2 -> ram[8'h10]=8'hC3.
REQ-032 Loader read of 8'h10 holding 8'hC3 -> ldr_valid=1 for one cycle with ldr_rdata=8'hC3 after the access edge; ldr_valid returns to 0.
REQ-033 Guard on, ldr_req held for 20 cycles -> exactly 8 accesses, HANDBACK, one CPU_OWN cycle with cpu_stall=0, then a new tenure; guard off -> 18 consecutive accesses.
REQ-034 reset_n pulsed low during LDR_OWN with ldr_we=1 -> ram_we=0 and cpu_stall=0 immediately; state is CPU_OWN after release.
REQ-035 cpu_we=1 held throughout a loader tenure -> ram_we is driven only by ldr_we; CPU data is never written while stalled.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x8 RAM port between the CPU and a loader/debug master.
// Define ARB_STARVE_GUARD_EN to cap each loader tenure at 8 accesses.
module mem_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    output logic       cpu_stall,
    input  logic       ldr_req,
    input  logic [7:0] ldr_addr,
    input  logic [7:0] ldr_wdata,
    input  logic       ldr_we,
    output logic       ldr_gnt,
    output logic [7:0] ldr_rdata,
    output logic       ldr_valid,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata
);
    typedef enum logic [1:0] {CPU_OWN, DRAIN, LDR_OWN, HANDBACK} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_access;
    logic       w_burst_done;
    logic       w_ram_we;
    logic       r_ldr_valid;
    logic [7:0] r_ldr_rdata;

    assign w_access = (r_state == LDR_OWN) && ldr_req;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_burst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_burst <= '0;
        else if (r_state == DRAIN)
            r_burst <= '0;
        else if (w_access)
            r_burst <= r_burst + 4'd1;
    end

    // seven accesses already done, so the current access edge is the 8th
    assign w_burst_done = (r_burst == 4'd7);
`else
    assign w_burst_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= CPU_OWN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_stall   = 1'b1;
        ldr_gnt     = 1'b0;
        ram_addr    = cpu_addr;
        ram_wdata   = cpu_wdata;
        w_ram_we    = 1'b0;
        case (r_state)
            CPU_OWN: begin
                cpu_stall = 1'b0;
                w_ram_we  = cpu_we;
                if (ldr_req)
                    w_state_nxt = DRAIN;
            end
            DRAIN: w_state_nxt = LDR_OWN;
            LDR_OWN: begin
                ldr_gnt   = 1'b1;
                ram_addr  = ldr_addr;
                ram_wdata = ldr_wdata;
                w_ram_we  = ldr_we & ldr_req;
                if (!ldr_req || w_burst_done)
                    w_state_nxt = HANDBACK;
            end
            HANDBACK: w_state_nxt = CPU_OWN;
            default:  w_state_nxt = CPU_OWN;
        endcase
    end

    // no RAM write may escape while reset is held, whoever the requester is
    assign ram_we    = w_ram_we & reset_n;
    assign cpu_rdata = ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ldr_valid <= 1'b0;
            r_ldr_rdata <= '0;
        end else begin
            r_ldr_valid <= w_access & ~ldr_we;
            if (w_access && !ldr_we)
                r_ldr_rdata <= ram_rdata;
        end
    end

    assign ldr_valid = r_ldr_valid;
    assign ldr_rdata = r_ldr_rdata;
endmodule
